// File: rtl/ff_lab_pkg.sv
// rtl/ff_lab_pkg.sv - shared types and constants for the flip-flop lab checkers
package ff_lab_pkg;

   typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

   localparam int         FLUSH_CYCLES = 2;
   localparam int         PIPE_DEPTH   = 2;
   localparam logic [7:0] LFSR_TAPS    = 8'hB8;

   // D_out / Q_in bit positions of the three converted flip-flops
   localparam int SR_BIT = 0;
   localparam int JK_BIT = 1;
   localparam int T_BIT  = 2;

   typedef struct packed {
      logic       valid;
      logic [2:0] expected;
      logic [7:0] idx;
   } chk_stage_t;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR, shift left with feedback into bit0
module lfsr8
   import ff_lab_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic [7:0] q
);

   logic [7:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = seed;
      end else if (advance) begin
         q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q <= 8'h01;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/ff_conv_checker.sv
// rtl/ff_conv_checker.sv - drives pseudo-random D vectors into the conversion circuit
// and checks each Q against the D issued two cycles earlier
module ff_conv_checker
   import ff_lab_pkg::*;
#(
   parameter int         N_VECTORS = 32,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   output logic [2:0] D_out,
   input  logic [2:0] Q_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [7:0] first_err_idx,
   output logic [2:0] first_err_mask
);

   localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [7:0] N_LAST   = 8'(N_VECTORS);

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] vec_idx_q, vec_idx_d;
   logic [2:0] d_out_q, d_out_d;
   logic [7:0] err_q, err_d;
   logic [7:0] fidx_q, fidx_d;
   logic [2:0] fmask_q, fmask_d;
   chk_stage_t pipe_q [PIPE_DEPTH];
   chk_stage_t stage0_d;
   logic       lfsr_load, lfsr_adv;
   logic [7:0] lfsr_q;
   logic [2:0] diff;

   lfsr8 u_lfsr (
      .CLK     (CLK),
      .RST     (RST),
      .load    (lfsr_load),
      .seed    (SEED_EFF),
      .advance (lfsr_adv),
      .q       (lfsr_q)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      vec_idx_d = vec_idx_q;
      d_out_d   = 3'b000;
      stage0_d  = '0;
      err_d     = err_q;
      fidx_d    = fidx_q;
      fmask_d   = fmask_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      diff      = pipe_q[PIPE_DEPTH-1].expected ^ Q_in;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = FLUSH;
               cnt_d     = 2'd0;
               vec_idx_d = 8'd0;
               err_d     = 8'd0;
               fidx_d    = 8'd0;
               fmask_d   = 3'b000;
               lfsr_load = 1'b1;
            end
         end
         FLUSH: begin
            if (cnt_q == 2'(FLUSH_CYCLES - 1)) begin
               state_d = RUN;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RUN: begin
            if (vec_idx_q == N_LAST) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_q == 2'(PIPE_DEPTH - 1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // D_out is registered, so a vector is issued on every edge that lands in RUN
      if (state_d == RUN) begin
         d_out_d           = lfsr_q[2:0];
         stage0_d.valid    = 1'b1;
         stage0_d.expected = lfsr_q[2:0];
         stage0_d.idx      = vec_idx_q;
         lfsr_adv          = 1'b1;
         vec_idx_d         = vec_idx_q + 8'd1;
      end

      if (pipe_q[PIPE_DEPTH-1].valid && (diff != 3'b000)) begin
         if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
         end
         if (err_q == 8'd0) begin
            fidx_d  = pipe_q[PIPE_DEPTH-1].idx;
            fmask_d = diff;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= 2'd0;
         vec_idx_q <= 8'd0;
         d_out_q   <= 3'b000;
         err_q     <= 8'd0;
         fidx_q    <= 8'd0;
         fmask_q   <= 3'b000;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vec_idx_q <= vec_idx_d;
         d_out_q   <= d_out_d;
         err_q     <= err_d;
         fidx_q    <= fidx_d;
         fmask_q   <= fmask_d;
         pipe_q[0] <= stage0_d;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign D_out          = d_out_q;
   assign busy           = (state_q == FLUSH) || (state_q == RUN) || (state_q == DRAIN);
   assign done           = (state_q == DONE);
   assign pass           = done && (err_q == 8'd0);
   assign err_count      = err_q;
   assign first_err_idx  = fidx_q;
   assign first_err_mask = fmask_q;

endmodule
